// File: rtl/bnn_pkg.sv
// Shared types and constants for the binarized MNIST classifier controller.
package bnn_pkg;

    localparam int PASS_W  = 11;
    localparam int CLASS_W = 4;

    localparam logic [1:0] LAYER_NONE = 2'd0;
    localparam logic [1:0] LAYER_C1   = 2'd1;
    localparam logic [1:0] LAYER_C2   = 2'd2;
    localparam logic [1:0] LAYER_FC   = 2'd3;

    typedef enum logic [2:0] {
        SEQ_IDLE     = 3'd0,
        SEQ_C1_ISSUE = 3'd1,
        SEQ_C1_WAIT  = 3'd2,
        SEQ_C2_ISSUE = 3'd3,
        SEQ_C2_WAIT  = 3'd4,
        SEQ_FC_ISSUE = 3'd5,
        SEQ_FC_WAIT  = 3'd6,
        SEQ_OUT      = 3'd7
    } seq_state_e;

    // One-hot kernel memory strobe for a layer code; code 0 selects nothing.
    function automatic logic [2:0] layer_onehot(input logic [1:0] code);
        logic [2:0] oh;
        oh = 3'b000;
        case (code)
            LAYER_C1: oh = 3'b001;
            LAYER_C2: oh = 3'b010;
            LAYER_FC: oh = 3'b100;
            default:  oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/bnn_argmax.sv
// Running argmax over the FC node scores; ties keep the lower index.
module bnn_argmax
    import bnn_pkg::*;
#(
    parameter int SCORE_W = 17,
    parameter int IDX_W   = CLASS_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clear,
    input  logic                      sample,
    input  logic signed [SCORE_W-1:0] score,
    input  logic        [IDX_W-1:0]   index,
    output logic signed [SCORE_W-1:0] best_score,
    output logic        [IDX_W-1:0]   best_idx
);

    // Node 0 always loads so the stale cleared value never competes; later
    // nodes replace the best only when strictly greater.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            best_score <= '0;
            best_idx   <= '0;
        end else if (sample && ((index == '0) || (score > best_score))) begin
            best_score <= score;
            best_idx   <= index;
        end
    end

endmodule

// File: rtl/bnn_layer_sequencer.sv
// Central controller: accepts an image, steps the shared layer engine through
// conv1, conv2 and FC passes, tracks the FC argmax and returns the class.
// Optional watchdog on engine completion is enabled by defining BNN_SEQ_TIMEOUT_EN.
module bnn_layer_sequencer
    import bnn_pkg::*;
#(
    parameter int C1_PASSES      = 18,
    parameter int C2_PASSES      = 60,
    parameter int FC_NODES       = 10,
    parameter int SCORE_W        = 17,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      image_in_valid,
    output logic                      image_in_ready,
    output logic                      image_latch,
    input  logic                      kernel_in_valid,
    input  logic [1:0]                kernel_layer,
    output logic                      kernel_in_ready,
    output logic [2:0]                kernel_wr_en,
    output logic                      layer_go,
    output logic [1:0]                layer_sel,
    output logic [PASS_W-1:0]         pass_idx,
    input  logic                      layer_done,
    input  logic signed [SCORE_W-1:0] fc_score,
    output logic                      class_out_valid,
    input  logic                      class_out_ready,
    output logic [CLASS_W-1:0]        class_out,
    output logic                      busy,
    output logic                      err_timeout
);

    localparam logic [2:0] S_IDLE     = SEQ_IDLE;
    localparam logic [2:0] S_C1_ISSUE = SEQ_C1_ISSUE;
    localparam logic [2:0] S_C1_WAIT  = SEQ_C1_WAIT;
    localparam logic [2:0] S_C2_ISSUE = SEQ_C2_ISSUE;
    localparam logic [2:0] S_C2_WAIT  = SEQ_C2_WAIT;
    localparam logic [2:0] S_FC_ISSUE = SEQ_FC_ISSUE;
    localparam logic [2:0] S_FC_WAIT  = SEQ_FC_WAIT;
    localparam logic [2:0] S_OUT      = SEQ_OUT;

    localparam logic [PASS_W-1:0] C1_LAST = PASS_W'(C1_PASSES - 1);
    localparam logic [PASS_W-1:0] C2_LAST = PASS_W'(C2_PASSES - 1);
    localparam logic [PASS_W-1:0] FC_LAST = PASS_W'(FC_NODES - 1);

    logic [2:0]               state;
    logic [2:0]               state_d;
    logic [PASS_W-1:0]        pass_d;
    logic [1:0]               sel_d;
    logic                     is_idle;
    logic                     is_issue;
    logic                     is_wait;
    logic                     image_fire;
    logic                     timeout_hit;
    logic                     argmax_clear;
    logic                     argmax_sample;
    logic signed [SCORE_W-1:0] best_score_unused;

    assign is_idle    = (state == S_IDLE);
    assign is_issue   = (state == S_C1_ISSUE) || (state == S_C2_ISSUE) || (state == S_FC_ISSUE);
    assign is_wait    = (state == S_C1_WAIT)  || (state == S_C2_WAIT)  || (state == S_FC_WAIT);
    assign image_fire = rst_n && is_idle && image_in_valid && !kernel_in_valid;

    // Host-facing handshakes: only IDLE accepts work, and a kernel write wins
    // over an image arriving in the same cycle.
    assign kernel_in_ready = is_idle;
    assign image_in_ready  = is_idle && !kernel_in_valid;
    assign image_latch     = image_fire;
    assign kernel_wr_en    = (rst_n && is_idle && kernel_in_valid) ? layer_onehot(kernel_layer) : 3'b000;

    assign layer_go        = is_issue;
    assign busy            = !is_idle;
    assign class_out_valid = (state == S_OUT);

    // Next state and pass counter; done is only honoured in the WAIT states.
    always_comb begin
        state_d = state;
        pass_d  = pass_idx;
        sel_d   = LAYER_NONE;
        case (state)
            S_IDLE: begin
                if (image_fire) begin
                    state_d = S_C1_ISSUE;
                    pass_d  = '0;
                end
            end
            S_C1_ISSUE: state_d = S_C1_WAIT;
            S_C2_ISSUE: state_d = S_C2_WAIT;
            S_FC_ISSUE: state_d = S_FC_WAIT;
            S_C1_WAIT: begin
                if (layer_done) begin
                    if (pass_idx == C1_LAST) begin
                        state_d = S_C2_ISSUE;
                        pass_d  = '0;
                    end else begin
                        state_d = S_C1_ISSUE;
                        pass_d  = pass_idx + PASS_W'(1);
                    end
                end else if (timeout_hit) begin
                    state_d = S_IDLE;
                    pass_d  = '0;
                end
            end
            S_C2_WAIT: begin
                if (layer_done) begin
                    if (pass_idx == C2_LAST) begin
                        state_d = S_FC_ISSUE;
                        pass_d  = '0;
                    end else begin
                        state_d = S_C2_ISSUE;
                        pass_d  = pass_idx + PASS_W'(1);
                    end
                end else if (timeout_hit) begin
                    state_d = S_IDLE;
                    pass_d  = '0;
                end
            end
            S_FC_WAIT: begin
                if (layer_done) begin
                    if (pass_idx == FC_LAST) begin
                        state_d = S_OUT;
                        pass_d  = '0;
                    end else begin
                        state_d = S_FC_ISSUE;
                        pass_d  = pass_idx + PASS_W'(1);
                    end
                end else if (timeout_hit) begin
                    state_d = S_IDLE;
                    pass_d  = '0;
                end
            end
            S_OUT: begin
                if (class_out_ready) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                pass_d  = '0;
            end
        endcase

        case (state_d)
            S_C1_ISSUE, S_C1_WAIT: sel_d = LAYER_C1;
            S_C2_ISSUE, S_C2_WAIT: sel_d = LAYER_C2;
            S_FC_ISSUE, S_FC_WAIT: sel_d = LAYER_FC;
            default:               sel_d = LAYER_NONE;
        endcase
    end

    // State, pass number and layer code are all registered together so the
    // engine sees them stable from ISSUE through the done cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            pass_idx  <= '0;
            layer_sel <= LAYER_NONE;
        end else begin
            state     <= state_d;
            pass_idx  <= pass_d;
            layer_sel <= sel_d;
        end
    end

    assign argmax_clear  = ((state == S_C2_WAIT) && (state_d == S_FC_ISSUE)) || timeout_hit;
    assign argmax_sample = (state == S_FC_WAIT) && layer_done;

    bnn_argmax #(
        .SCORE_W (SCORE_W),
        .IDX_W   (CLASS_W)
    ) u_argmax (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (argmax_clear),
        .sample     (argmax_sample),
        .score      (fc_score),
        .index      (pass_idx[CLASS_W-1:0]),
        .best_score (best_score_unused),
        .best_idx   (class_out)
    );

`ifdef BNN_SEQ_TIMEOUT_EN
    logic [12:0] wd_cnt;
    logic        err_q;

    assign timeout_hit = is_wait && !layer_done && (wd_cnt == 13'(TIMEOUT_CYCLES - 1));
    assign err_timeout = err_q;

    // Watchdog restarts at every pass start and counts the cycles spent waiting.
    always_ff @(posedge clk) begin
        if (!rst_n || is_issue) begin
            wd_cnt <= '0;
        end else if (is_wait && !layer_done) begin
            wd_cnt <= wd_cnt + 13'd1;
        end
    end

    // Error pulse lines up with the cycle the controller is back in IDLE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= timeout_hit;
        end
    end
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign timeout_hit = 1'b0;
    assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_bnn_layer_sequencer.sv
// Self-checking bench for bnn_layer_sequencer with a layer-engine driver.
`timescale 1ns/1ps
module tb_bnn_layer_sequencer;

    localparam int C1P   = 18;
    localparam int C2P   = 60;
    localparam int FCN   = 10;
    localparam int SW    = 17;
    localparam int TOC   = 16;
    localparam int TOTAL = C1P + C2P + FCN;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 image_in_valid = 1'b0;
    logic                 image_in_ready;
    logic                 image_latch;
    logic                 kernel_in_valid = 1'b0;
    logic [1:0]           kernel_layer = 2'd0;
    logic                 kernel_in_ready;
    logic [2:0]           kernel_wr_en;
    logic                 layer_go;
    logic [1:0]           layer_sel;
    logic [10:0]          pass_idx;
    logic                 layer_done;
    logic signed [SW-1:0] fc_score = '0;
    logic                 class_out_valid;
    logic                 class_out_ready = 1'b0;
    logic [3:0]           class_out;
    logic                 busy;
    logic                 err_timeout;

    logic eng_done = 1'b0;
    logic tb_done  = 1'b0;
    assign layer_done = eng_done | tb_done;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int go_count = 0;
    int err_seen = 0;

    bnn_layer_sequencer #(
        .C1_PASSES      (C1P),
        .C2_PASSES      (C2P),
        .FC_NODES       (FCN),
        .SCORE_W        (SW),
        .TIMEOUT_CYCLES (TOC)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .image_in_valid  (image_in_valid),
        .image_in_ready  (image_in_ready),
        .image_latch     (image_latch),
        .kernel_in_valid (kernel_in_valid),
        .kernel_layer    (kernel_layer),
        .kernel_in_ready (kernel_in_ready),
        .kernel_wr_en    (kernel_wr_en),
        .layer_go        (layer_go),
        .layer_sel       (layer_sel),
        .pass_idx        (pass_idx),
        .layer_done      (layer_done),
        .fc_score        (fc_score),
        .class_out_valid (class_out_valid),
        .class_out_ready (class_out_ready),
        .class_out       (class_out),
        .busy            (busy),
        .err_timeout     (err_timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (err_timeout === 1'b1) err_seen <= err_seen + 1;

    initial begin
        #500000;
        $display("[TB] FAIL global_watchdog bench did not finish in time");
        $fatal(1, "[TB] global watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Winner of the FC scores: largest value, earliest index on ties.
    function automatic int model_argmax(input int sc[FCN]);
        int best = 0;
        for (int i = 1; i < FCN; i++) if (sc[i] > sc[best]) best = i;
        return best;
    endfunction

    // Plays the layer engine for one pass: waits for go, checks which pass the
    // controller asked for, optionally stalls, then returns done with a score.
    task automatic run_pass(input int exp_sel, input int exp_idx, input int extra, input int score);
        int waited = 0;
        @(negedge clk);
        while (layer_go !== 1'b1 && waited < 8) begin
            tick();
            @(negedge clk);
            waited++;
        end
        checks++;
        if (layer_go !== 1'b1) begin
            errors++;
            $display("[TB] FAIL go_wait no layer_go within 8 cycles (sel=%0d idx=%0d required)", exp_sel, exp_idx);
            return;
        end
        go_count++;
        checks++;
        if (layer_sel !== 2'(exp_sel) || pass_idx !== 11'(exp_idx)) begin
            errors++;
            $display("[TB] FAIL pass_id got sel=%0d idx=%0d required sel=%0d idx=%0d", layer_sel, pass_idx, exp_sel, exp_idx);
        end
        for (int w = 0; w < extra; w++) tick();
        tick();
        eng_done = 1'b1;
        fc_score = SW'(score);
        @(negedge clk);
        checks++;
        if (layer_sel !== 2'(exp_sel) || pass_idx !== 11'(exp_idx) || layer_go !== 1'b0) begin
            errors++;
            $display("[TB] FAIL pass_stable at done got sel=%0d idx=%0d go=%0b required sel=%0d idx=%0d go=0", layer_sel, pass_idx, layer_go, exp_sel, exp_idx);
        end
        tick();
        eng_done = 1'b0;
        fc_score = '0;
    endtask

    // Offers an image in IDLE and returns the handshake cycle.
    task automatic start_image(output int t0);
        image_in_valid = 1'b1;
        @(negedge clk);
        t0 = cyc;
        checks++;
        if (image_in_ready !== 1'b1 || image_latch !== 1'b1) begin
            errors++;
            $display("[TB] FAIL image_accept got ready=%0b latch=%0b required 1/1", image_in_ready, image_latch);
        end
        tick();
        image_in_valid = 1'b0;
    endtask

    // Runs a layer sequence from the given C1/C2/FC starting passes.
    task automatic run_layers(input int c1_from, input int c2_from, input int fc_from, input int extra_max,
                              input int sc[FCN], output int k_total);
        int e;
        k_total = 0;
        for (int i = c1_from; i < C1P; i++) begin
            e = int'($urandom_range(extra_max, 0)); k_total += e; run_pass(1, i, e, 0);
        end
        for (int i = c2_from; i < C2P; i++) begin
            e = int'($urandom_range(extra_max, 0)); k_total += e; run_pass(2, i, e, 0);
        end
        for (int i = fc_from; i < FCN; i++) begin
            e = int'($urandom_range(extra_max, 0)); k_total += e; run_pass(3, i, e, sc[i]);
        end
    endtask

    // Waits for the result, checks timing and class, holds, then completes it.
    task automatic finish_out(input int exp_class, input int exp_cyc, input int hold);
        int waited = 0;
        @(negedge clk);
        while (class_out_valid !== 1'b1 && waited < 50) begin
            tick();
            @(negedge clk);
            waited++;
        end
        checks++;
        if (class_out_valid !== 1'b1 || cyc != exp_cyc) begin
            errors++;
            $display("[TB] FAIL out_latency got valid=%0b at cycle %0d required valid at %0d", class_out_valid, cyc, exp_cyc);
        end
        checks++;
        if (class_out !== 4'(exp_class)) begin
            errors++;
            $display("[TB] FAIL class got %0d required %0d", class_out, exp_class);
        end
        for (int h = 0; h < hold; h++) begin
            tick();
            @(negedge clk);
            checks++;
            if (class_out_valid !== 1'b1 || class_out !== 4'(exp_class)) begin
                errors++;
                $display("[TB] FAIL out_hold cycle %0d got valid=%0b class=%0d required 1/%0d", h, class_out_valid, class_out, exp_class);
            end
        end
        class_out_ready = 1'b1;
        tick();
        class_out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || class_out_valid !== 1'b0 || image_in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL out_release got busy=%0b valid=%0b img_rdy=%0b required 0/0/1", busy, class_out_valid, image_in_ready);
        end
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({image_in_ready, kernel_in_ready, busy, class_out_valid} !== 4'b1100) begin
            errors++;
            $display("[TB] FAIL reset_status got img_rdy=%0b k_rdy=%0b busy=%0b valid=%0b required 1/1/0/0",
                     image_in_ready, kernel_in_ready, busy, class_out_valid);
        end
        checks++;
        if ({layer_go, image_latch, kernel_wr_en, layer_sel, pass_idx, class_out, err_timeout} !== 24'd0) begin
            errors++;
            $display("[TB] FAIL reset_zero got go=%0b latch=%0b wr=%b sel=%0d idx=%0d class=%0d err=%0b required all 0",
                     layer_go, image_latch, kernel_wr_en, layer_sel, pass_idx, class_out, err_timeout);
        end
        tick();
    endtask

    task automatic test_image_directed();
        int sc[FCN] = '{5, -3, 12, 12, 0, -20, 7, 12, -65536, 1};
        int t0, k;
        go_count = 0;
        start_image(t0);
        run_layers(0, 0, 0, 0, sc, k);
        checks++;
        if (go_count != TOTAL) begin
            errors++;
            $display("[TB] FAIL go_count got %0d required %0d", go_count, TOTAL);
        end
        finish_out(model_argmax(sc), t0 + 177, 0);
    endtask

    task automatic test_random_images();
        int sc[FCN];
        int t0, k;
        for (int n = 0; n < 3; n++) begin
            for (int i = 0; i < FCN; i++) begin
                if (n % 2 == 0) sc[i] = int'($urandom_range(8, 0)) - 4;
                else            sc[i] = int'($urandom_range(131071, 0)) - 65536;
            end
            start_image(t0);
            run_layers(0, 0, 0, 3, sc, k);
            finish_out(model_argmax(sc), t0 + 1 + 2 * TOTAL + k, int'($urandom_range(3, 0)));
        end
    endtask

    task automatic test_kernel_writes();
        int lay;
        logic [2:0] exp_wr;
        for (int n = 0; n < 8; n++) begin
            lay = (n < 4) ? n : int'($urandom_range(3, 0));
            exp_wr = (lay == 0) ? 3'b000 : 3'(1 << (lay - 1));
            kernel_in_valid = 1'b1;
            kernel_layer = 2'(lay);
            image_in_valid = 1'($urandom_range(1, 0));
            @(negedge clk);
            checks++;
            if (kernel_wr_en !== exp_wr || kernel_in_ready !== 1'b1 || image_in_ready !== 1'b0 || image_latch !== 1'b0) begin
                errors++;
                $display("[TB] FAIL kernel_write layer=%0d got wr=%b k_rdy=%0b img_rdy=%0b latch=%0b required wr=%b 1/0/0",
                         lay, kernel_wr_en, kernel_in_ready, image_in_ready, image_latch, exp_wr);
            end
            tick();
        end
        kernel_in_valid = 1'b0;
        image_in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL kernel_no_start got busy=%0b required 0", busy);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int sc[FCN] = '{-1, 4, 4, 9, 9, -8, 0, 2, 9, 3};
        int t0, k;
        kernel_in_valid = 1'b1;
        kernel_layer = 2'd2;
        image_in_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (kernel_wr_en !== 3'b010 || image_in_ready !== 1'b0 || image_latch !== 1'b0) begin
            errors++;
            $display("[TB] FAIL arb_kernel_wins got wr=%b img_rdy=%0b latch=%0b required 010/0/0", kernel_wr_en, image_in_ready, image_latch);
        end
        tick();
        kernel_in_valid = 1'b0;
        start_image(t0);
        tb_done = 1'b1;
        @(negedge clk);
        checks++;
        if (layer_go !== 1'b1 || pass_idx !== 11'd0 || layer_sel !== 2'd1) begin
            errors++;
            $display("[TB] FAIL c1_issue got go=%0b idx=%0d sel=%0d required 1/0/1", layer_go, pass_idx, layer_sel);
        end
        tick();
        tb_done = 1'b0;
        for (int w = 0; w < 2; w++) begin
            @(negedge clk);
            checks++;
            if (layer_go !== 1'b0 || pass_idx !== 11'd0 || busy !== 1'b1) begin
                errors++;
                $display("[TB] FAIL done_in_issue_ignored wait %0d got go=%0b idx=%0d required 0/0", w, layer_go, pass_idx);
            end
            if (w == 0) tick();
        end
        tb_done = 1'b1;
        tick();
        tb_done = 1'b0;
        run_layers(1, C2P, FCN, 0, sc, k);
        @(negedge clk);
        checks++;
        if (layer_go !== 1'b1 || layer_sel !== 2'd2 || pass_idx !== 11'd0) begin
            errors++;
            $display("[TB] FAIL c2_issue got go=%0b sel=%0d idx=%0d required 1/2/0", layer_go, layer_sel, pass_idx);
        end
        tick();
        kernel_in_valid = 1'b1;
        kernel_layer = 2'd2;
        image_in_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (kernel_in_ready !== 1'b0 || kernel_wr_en !== 3'b000 || image_in_ready !== 1'b0 || image_latch !== 1'b0) begin
            errors++;
            $display("[TB] FAIL busy_refuse got k_rdy=%0b wr=%b img_rdy=%0b latch=%0b required 0/000/0/0",
                     kernel_in_ready, kernel_wr_en, image_in_ready, image_latch);
        end
        tick();
        kernel_in_valid = 1'b0;
        image_in_valid = 1'b0;
        tb_done = 1'b1;
        tick();
        tb_done = 1'b0;
        run_layers(C1P, 1, 0, 0, sc, k);
        // C1 pass 0 and C2 pass 0 each spent one extra cycle in WAIT.
        finish_out(model_argmax(sc), t0 + 1 + 2 * TOTAL + 2, 20);
    endtask

    task automatic test_reset_mid_inference();
        int sc[FCN] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        int t0, k, bad;
        start_image(t0);
        run_layers(0, C2P, FCN, 0, sc, k);
        for (int i = 0; i < 5; i++) run_pass(2, i, 0, 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || layer_sel !== 2'd0 || pass_idx !== 11'd0 || class_out !== 4'd0 || class_out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_abort got busy=%0b sel=%0d idx=%0d class=%0d valid=%0b required 0/0/0/0/0",
                     busy, layer_sel, pass_idx, class_out, class_out_valid);
        end
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            @(negedge clk);
            if (class_out_valid !== 1'b0 || layer_go !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("[TB] FAIL abort_quiet got %0d cycles with valid/go required 0", bad);
        end
        tick();
    endtask

    task automatic test_timeout();
`ifdef BNN_SEQ_TIMEOUT_EN
        int sc[FCN] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        int t0, bad;
        start_image(t0);
        for (int i = 0; i < 3; i++) run_pass(1, i, 0, 0);
        @(negedge clk);
        checks++;
        if (layer_go !== 1'b1 || pass_idx !== 11'd3) begin
            errors++;
            $display("[TB] FAIL to_issue got go=%0b idx=%0d required 1/3", layer_go, pass_idx);
        end
        bad = 0;
        for (int w = 0; w < TOC; w++) begin
            tick();
            @(negedge clk);
            if (busy !== 1'b1 || err_timeout !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("[TB] FAIL to_early got %0d bad wait cycles required 0", bad);
        end
        tick();
        @(negedge clk);
        checks++;
        if (err_timeout !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL to_fire got err=%0b busy=%0b required 1/0", err_timeout, busy);
        end
        tick();
        @(negedge clk);
        checks++;
        if (err_timeout !== 1'b0 || err_seen != 1) begin
            errors++;
            $display("[TB] FAIL to_pulse got err=%0b pulses=%0d required 0/1", err_timeout, err_seen);
        end
        tick();
        start_image(t0);
        run_layers(0, 0, 0, 0, sc, bad);
        finish_out(0, t0 + 177, 0);
`else
        @(negedge clk);
        checks++;
        if (err_seen != 0 || err_timeout !== 1'b0) begin
            errors++;
            $display("[TB] FAIL no_watchdog got %0d err pulses required 0", err_seen);
        end
        tick();
`endif
    endtask

    initial begin
        $display("[TB] starting bnn_layer_sequencer bench");
        test_reset();
        test_image_directed();
        test_kernel_writes();
        test_back_to_back();
        test_random_images();
        test_reset_mid_inference();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
